// File: rtl/uart_word_packer.sv
// Packs UART receive bytes into little-endian words with idle-timeout flush of partial words.
// Accumulator plus output register; bytes that cannot be stored are dropped and flagged.
module uart_word_packer #(
    parameter int BYTE_W  = 8,
    parameter int BYTES   = 4,
    parameter int TIMEOUT = 86800
) (
    input  logic                         CLK100MHZ,
    input  logic                         RESETN,
    input  logic [BYTE_W-1:0]            RX_DATA,
    input  logic                         RX_DONE,
    output logic [BYTE_W*BYTES-1:0]      WORD,
    output logic                         WORD_VALID,
    input  logic                         WORD_READY,
    output logic [$clog2(BYTES+1)-1:0]   WORD_LEN,
    output logic                         PARTIAL,
    output logic                         OVERRUN,
    input  logic                         CLEAR_ERR,
    output logic [1:0]                   o_dbg_state
);

    localparam int WORD_W = BYTE_W * BYTES;
    localparam int LEN_W  = $clog2(BYTES + 1);
    localparam int TMR_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PEND    = 2'd2
    } state_t;

    state_t             r_state;
    logic [WORD_W-1:0]  r_acc;
    logic [LEN_W-1:0]   r_cnt;
    logic [TMR_W-1:0]   r_timer;
    logic               r_pend_partial;

    logic [WORD_W-1:0]  r_word;
    logic               r_word_valid;
    logic [LEN_W-1:0]   r_word_len;
    logic               r_partial;
    logic               r_overrun;

    logic               w_out_free;
    logic [WORD_W-1:0]  w_acc_ins;
    logic [LEN_W-1:0]   w_cnt_inc;
    logic               w_full;
    logic               w_flush;
    logic               w_produce;
    logic               w_drop;
    logic [WORD_W-1:0]  w_prod_word;
    logic [LEN_W-1:0]   w_prod_len;
    logic               w_prod_partial;

    // Handshake: a word transfers on any rising edge where WORD_VALID and WORD_READY are both 1;
    // WORD/WORD_LEN/PARTIAL never change while WORD_VALID=1 and WORD_READY=0.
    always_comb begin
        w_out_free = !r_word_valid || WORD_READY;
        w_acc_ins  = r_acc;
        for (int i = 0; i < BYTES; i++) begin
            if (r_cnt == LEN_W'(i)) begin
                w_acc_ins[i*BYTE_W +: BYTE_W] = RX_DATA;
            end
        end
        w_cnt_inc = r_cnt + LEN_W'(1);

        w_full    = (r_state != ST_PEND) && RX_DONE && (w_cnt_inc == LEN_W'(BYTES));
        // The byte wins over a flush in the same cycle; firing one cycle early makes
        // WORD_VALID rise exactly TIMEOUT cycles after the last strobe.
        w_flush   = (r_state == ST_COLLECT) && !RX_DONE && (r_timer == TMR_W'(TIMEOUT - 2));
        w_produce = w_full || w_flush || (r_state == ST_PEND);
        w_drop    = (r_state == ST_PEND) && RX_DONE && !w_out_free;

        w_prod_word    = w_full ? w_acc_ins : r_acc;
        w_prod_len     = w_full ? LEN_W'(BYTES) : r_cnt;
        w_prod_partial = (r_state == ST_PEND) ? r_pend_partial : w_flush;
    end

    always_ff @(posedge CLK100MHZ or negedge RESETN) begin
        if (!RESETN) begin
            r_state        <= ST_EMPTY;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_timer        <= '0;
            r_pend_partial <= 1'b0;
            r_word         <= '0;
            r_word_valid   <= 1'b0;
            r_word_len     <= '0;
            r_partial      <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (w_produce && w_out_free) begin
                r_word       <= w_prod_word;
                r_word_len   <= w_prod_len;
                r_partial    <= w_prod_partial;
                r_word_valid <= 1'b1;
            end else if (WORD_READY) begin
                r_word_valid <= 1'b0;
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (CLEAR_ERR) begin
                r_overrun <= 1'b0;
            end

            case (r_state)
                ST_EMPTY, ST_COLLECT: begin
                    if (RX_DONE) begin
                        r_timer <= '0;
                        if (w_full && w_out_free) begin
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_EMPTY;
                        end else begin
                            r_acc          <= w_acc_ins;
                            r_cnt          <= w_cnt_inc;
                            r_pend_partial <= 1'b0;
                            r_state        <= w_full ? ST_PEND : ST_COLLECT;
                        end
                    end else if (w_flush) begin
                        r_timer        <= '0;
                        r_pend_partial <= 1'b1;
                        if (w_out_free) begin
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_EMPTY;
                        end else begin
                            r_state <= ST_PEND;
                        end
                    end else if (r_state == ST_COLLECT) begin
                        r_timer <= r_timer + TMR_W'(1);
                    end else begin
                        r_timer <= '0;
                    end
                end
                ST_PEND: begin
                    if (w_out_free) begin
                        // A byte arriving in the drain cycle starts the next word in lane 0.
                        if (RX_DONE) begin
                            r_acc   <= WORD_W'(RX_DATA);
                            r_cnt   <= LEN_W'(1);
                            r_state <= ST_COLLECT;
                        end else begin
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_EMPTY;
                        end
                        r_timer <= '0;
                    end
                end
                default: begin
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    assign WORD        = r_word;
    assign WORD_VALID  = r_word_valid;
    assign WORD_LEN    = r_word_len;
    assign PARTIAL     = r_partial;
    assign OVERRUN     = r_overrun;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_word_packer.sv
// Directed bench for uart_word_packer: full words, timeout flush, back-pressure/overrun,
// PEND-drain byte capture, byte-vs-flush collision and mid-word reset.
module tb_uart_word_packer;
  localparam int BYTE_W  = 8;
  localparam int BYTES   = 4;
  localparam int TIMEOUT = 16;
  localparam int WORD_W  = BYTE_W * BYTES;
  localparam int LEN_W   = $clog2(BYTES + 1);
  localparam int REC_W   = WORD_W + LEN_W + 1;

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_PEND    = 2'd2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [BYTE_W-1:0] rx_data;
  logic              rx_done;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              word_ready;
  logic [LEN_W-1:0]  word_len;
  logic              partial;
  logic              overrun;
  logic              clear_err;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] obs_q[$];

  // clock / reset
  always #5 clk = ~clk;

  uart_word_packer #(
    .BYTE_W (BYTE_W),
    .BYTES  (BYTES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK100MHZ  (clk),
    .RESETN     (rst_n),
    .RX_DATA    (rx_data),
    .RX_DONE    (rx_done),
    .WORD       (word),
    .WORD_VALID (word_valid),
    .WORD_READY (word_ready),
    .WORD_LEN   (word_len),
    .PARTIAL    (partial),
    .OVERRUN    (overrun),
    .CLEAR_ERR  (clear_err),
    .o_dbg_state(dbg_state)
  );

  // handshake monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n && word_valid && word_ready) obs_q.push_back({partial, word_len, word});
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [BYTE_W-1:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick(1);
    rx_done = 1'b0;
  endtask

  function automatic logic [REC_W-1:0] rec(input logic [WORD_W-1:0] w, input int len,
                                           input logic part);
    return {part, LEN_W'(len), w};
  endfunction

  task automatic score(input string tag);
    int n;
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_word%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    rx_data    = '0;
    rx_done    = 1'b0;
    word_ready = 1'b0;
    clear_err  = 1'b0;
    tick(3);
    check("rst_valid", word_valid, 0);
    check("rst_word", word, 0);
    check("rst_len", word_len, 0);
    check("rst_partial", partial, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dbg_state, ST_EMPTY);
    rst_n = 1'b1;
    tick(1);

    // full word, ready held high
    word_ready = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("t1_not_yet", word_valid, 0);
    send_byte(8'h44);
    check("t1_valid", word_valid, 1);
    check("t1_word", word, 32'h44332211);
    check("t1_len", word_len, 4);
    check("t1_partial", partial, 0);
    tick(1);
    check("t1_one_cycle", word_valid, 0);
    exp_q.push_back(rec(32'h44332211, 4, 1'b0));
    score("t1");

    // timeout flush of a 2-byte partial word
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick(TIMEOUT - 2);
    check("t2_early", word_valid, 0);
    tick(1);
    check("t2_valid", word_valid, 1);
    check("t2_word", word, 32'h0000BBAA);
    check("t2_len", word_len, 2);
    check("t2_partial", partial, 1);
    tick(3 * TIMEOUT);
    exp_q.push_back(rec(32'h0000BBAA, 2, 1'b1));
    score("t2");

    // back-pressure: one word held, one pending, four dropped
    word_ready = 1'b0;
    for (int i = 1; i <= 12; i++) send_byte(BYTE_W'(i));
    check("t3_valid", word_valid, 1);
    check("t3_held", word, 32'h04030201);
    check("t3_state_pend", dbg_state, ST_PEND);
    check("t3_overrun", overrun, 1);
    word_ready = 1'b1;
    tick(1);
    check("t3_second_valid", word_valid, 1);
    check("t3_second", word, 32'h08070605);
    tick(1);
    check("t3_drained", word_valid, 0);
    check("t3_state_empty", dbg_state, ST_EMPTY);
    check("t3_sticky", overrun, 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check("t3_cleared", overrun, 0);
    tick(2 * TIMEOUT);
    exp_q.push_back(rec(32'h04030201, 4, 1'b0));
    exp_q.push_back(rec(32'h08070605, 4, 1'b0));
    score("t3");

    // byte arriving in the PEND-drain cycle
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + BYTE_W'(i));
    for (int i = 0; i < 4; i++) send_byte(8'hB0 + BYTE_W'(i));
    check("t4_state_pend", dbg_state, ST_PEND);
    word_ready = 1'b1;
    send_byte(8'h55);
    check("t4_drain_word", word, 32'hB3B2B1B0);
    check("t4_state_collect", dbg_state, ST_COLLECT);
    check("t4_no_overrun", overrun, 0);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    check("t4_next_word", word, 32'h88776655);
    check("t4_next_valid", word_valid, 1);
    tick(1);
    exp_q.push_back(rec(32'hA3A2A1A0, 4, 1'b0));
    exp_q.push_back(rec(32'hB3B2B1B0, 4, 1'b0));
    exp_q.push_back(rec(32'h88776655, 4, 1'b0));
    score("t4");

    // byte strobed in the cycle the flush would fire
    send_byte(8'hC1);
    tick(TIMEOUT - 2);
    send_byte(8'hC2);
    check("t5_no_flush", word_valid, 0);
    check("t5_state", dbg_state, ST_COLLECT);
    send_byte(8'hC3);
    send_byte(8'hC4);
    check("t5_valid", word_valid, 1);
    check("t5_word", word, 32'hC4C3C2C1);
    check("t5_len", word_len, 4);
    check("t5_partial", partial, 0);
    tick(1);
    exp_q.push_back(rec(32'hC4C3C2C1, 4, 1'b0));
    score("t5");

    // asynchronous reset mid-word
    word_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'hE0 + BYTE_W'(i));
    send_byte(8'hD1);
    send_byte(8'hD2);
    send_byte(8'hD3);
    check("t6_pre_valid", word_valid, 1);
    check("t6_pre_state", dbg_state, ST_COLLECT);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", word_valid, 0);
    check("t6_rst_word", word, 0);
    check("t6_rst_len", word_len, 0);
    check("t6_rst_partial", partial, 0);
    check("t6_rst_state", dbg_state, ST_EMPTY);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    word_ready = 1'b1;
    send_byte(8'hF1);
    send_byte(8'hF2);
    send_byte(8'hF3);
    send_byte(8'hF4);
    check("t6_word", word, 32'hF4F3F2F1);
    check("t6_len", word_len, 4);
    tick(2 * TIMEOUT);
    exp_q.push_back(rec(32'hF4F3F2F1, 4, 1'b0));
    score("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/uart_word_packer.md
# uart_word_packer

Receive-side packing stage sitting directly downstream of the UART receiver (`UART_RX` byte plus one-cycle `DONE` strobe). It assembles consecutive received bytes into `BYTES`-wide little-endian words for the DNN input loader, flushes a zero-padded partial word after a line-idle timeout, and presents completed words on a valid/ready handshake. Since the UART cannot be stalled, the block double-buffers (accumulator plus output register) and flags bytes it is forced to drop.

## Interface
- `BYTE_W`, 8: bits per received byte.
- `BYTES`, 4: bytes per output word; legal range 2..8.
- `TIMEOUT`, 86800: idle cycles before a partial word is flushed (10 characters at 115200 baud on 100 MHz); must be ≥ 2.
- `CLK100MHZ`  in  1  system clock; all logic is on the rising edge.
- `RESETN`  in  1  asynchronous, active-low reset.
- `RX_DATA`  in  BYTE_W  received byte; valid only while `RX_DONE`=1.
- `RX_DONE`  in  1  one-cycle strobe marking a new byte.
- `WORD`  out  BYTE_W*BYTES  output word; byte 0 (the first received) is in `[BYTE_W-1:0]`.
- `WORD_VALID`  out  1  output register holds a word.
- `WORD_READY`  in  1  consumer accepts the word when `WORD_VALID`&`WORD_READY`.
- `WORD_LEN`  out  $clog2(BYTES+1)  number of real bytes in `WORD`. It equals `BYTES` for a full word and 1..BYTES-1 for a timeout flush.
- `PARTIAL`  out  1  current word was produced by the timeout flush.
- `OVERRUN`  out  1  sticky flag: at least one byte was dropped.
- `CLEAR_ERR`  in  1  synchronous clear of `OVERRUN`.

## Operation
- The accumulator holds `acc`, a byte count `cnt` (0..BYTES), and a `pend` flag meaning the accumulator holds a word waiting for the output register.
- Accumulator states:
  - EMPTY: `cnt`=0.
  - COLLECT: 0<`cnt`<`BYTES`.
  - PEND: `pend`=1.
- When `RX_DONE`=1 in EMPTY or COLLECT, `RX_DATA` is written to byte lane `cnt` and `cnt` increments.
  - If `cnt` reaches `BYTES`, a full word is produced: LEN=`BYTES`, PARTIAL=0.
- Idle timer:
  - Cleared on every accepted byte and whenever `cnt`=0.
  - Increments every cycle in COLLECT.
  - On reaching `TIMEOUT`-1 it produces a partial word: unfilled lanes are 0, LEN=`cnt`, PARTIAL=1.
- A produced word moves to the output register if the register is free in that cycle, meaning `WORD_VALID`=0 or a handshake is occurring. The accumulator then returns to EMPTY.
- If the register is not free, the accumulator enters PEND with its contents frozen. It moves to the output on the first free cycle, then goes to EMPTY.
- An `RX_DONE` that arrives while in PEND is dropped and sets `OVERRUN`. The one exception is the cycle in which PEND drains: that byte is accepted as lane 0 of the new word.
- Output register: loads `WORD`/`WORD_LEN`/`PARTIAL` and sets `WORD_VALID`. Contents stay stable while `WORD_VALID`=1 and `WORD_READY`=0. `WORD_VALID` clears on a handshake unless it is reloaded in the same cycle.
- `OVERRUN` set has priority over `CLEAR_ERR` in the same cycle.
- The timeout flush and a byte arrival in the same cycle: the byte wins. It is accepted, the timer clears, and no flush occurs.

## Timing
- Reset (async assert, sync release by design convention) values:
  - `WORD`=0, `WORD_VALID`=0, `WORD_LEN`=0, `PARTIAL`=0, `OVERRUN`=0.
  - `cnt`=0, `pend`=0, timer=0.
- Latency: a completing byte strobed in cycle t gives `WORD_VALID`=1 in cycle t+1 when the output is free.
- Timeout flush: with the last byte strobed in cycle t, `WORD_VALID` rises in cycle t+`TIMEOUT`.
- Throughput: one word per cycle at the output when `WORD_READY` is held high. This is far faster than UART byte rate.
- Reset asserted mid-word discards all accumulated and pending data without emitting anything.

## Test plan
- BYTES=4: strobe 0x11,0x22,0x33,0x44 with `WORD_READY`=1. Expect `WORD`=0x44332211, LEN=4, PARTIAL=0, `WORD_VALID` for one cycle, one cycle after the 0x44 strobe.
- Strobe 0xAA,0xBB and then stay idle. Expect `WORD`=0x0000BBAA, LEN=2, PARTIAL=1 exactly `TIMEOUT` cycles after the 0xBB strobe; no further words after that.
- Hold `WORD_READY`=0 and send 12 bytes 0x01..0x0C:
  - Word 0x04030201 is held in the output and 0x08070605 in PEND.
  - Bytes 0x09..0x0C are dropped and `OVERRUN`=1.
  - Raise `WORD_READY`: exactly two words emerge in order, then `CLEAR_ERR` sets `OVERRUN` to 0.
- Back-pressure release coinciding with `RX_DONE` of 0x55 in the PEND-drain cycle. Expect 0x55 to be accepted as lane 0 of the next word and `OVERRUN` to stay 0.
- A byte strobe in the same cycle the timer would fire: no partial flush, and `cnt` increments.
- Assert `RESETN`=0 asynchronously after 3 bytes, then release and send 4 bytes. Expect all outputs at reset values immediately, and that the first word contains only the post-reset bytes.
